// File: rtl/dsp_pkg.sv
// dsp_pkg: shared sample width, mode encodings and shift-with-saturation helper
package dsp_pkg;
    localparam int SAMPLE_W = 18;
    localparam logic MODE_ZS = 1'b0;
    localparam logic MODE_HOLD = 1'b1;

    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x, input int sh, input int w, output logic ov);
        logic signed [63:0] s, hi, lo;
        s = x <<< sh;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        ov = (s > hi) || (s < lo);
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction
endpackage

// File: rtl/interp_lane.sv
// interp_lane: per-channel hold register, gain shift with saturation, output mux and sticky flag
module interp_lane
    import dsp_pkg::*;
#(
    parameter int W = SAMPLE_W,
    parameter int GAIN_COMP = 1,
    parameter int LW = 2
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                adv,
    input  logic                sync,
    input  logic                first,
    input  logic                mode,
    input  logic [LW-1:0]       l_act,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y,
    output logic                sat_flag
);
    logic signed [W-1:0] hold, gx;
    logic signed [63:0] wide;
    logic ov;

    always_comb begin
        wide = sat_shift(64'(x), (GAIN_COMP != 0) ? int'(l_act) : 0, W, ov);
        gx = wide[W-1:0];
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset || sync) begin
            hold <= '0;
            y <= '0;
            sat_flag <= 1'b0;
        end else if (adv) begin
            if (first) begin
                hold <= x;
                y <= (mode == MODE_HOLD) ? x : gx;
                sat_flag <= sat_flag | ((mode == MODE_ZS) & ov);
            end else begin
                y <= (mode == MODE_HOLD) ? hold : '0;
            end
        end
    end
endmodule

// File: rtl/interp_zero_stuff.sv
// interp_zero_stuff: multi-channel 2^l interpolator (zero-stuff or sample-and-hold) with shared phase counter
module interp_zero_stuff
    import dsp_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W = SAMPLE_W,
    parameter int MAX_LOG2L = 3,
    parameter int GAIN_COMP = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 out_en,
    input  logic                 sync,
    input  logic                 mode,
    input  logic [2:0]           log2_l,
    input  logic [NCH*W-1:0]     x_in,
    output logic                 in_req,
    output logic [NCH*W-1:0]     y,
    output logic                 y_valid,
    output logic [MAX_LOG2L-1:0] phase,
    output logic [NCH-1:0]       sat_flag
);
    localparam int LW = $clog2(MAX_LOG2L + 1);

    logic [LW-1:0] l_act, l_req;
    logic [MAX_LOG2L-1:0] last;
    logic wrap;

    always_comb begin
        l_req = (log2_l > 3'(MAX_LOG2L)) ? LW'(MAX_LOG2L) : LW'(log2_l);
        last = MAX_LOG2L'((1 << l_act) - 1);
        wrap = phase == last;
        in_req = phase == '0;
    end

    // l_act only changes at a frame boundary so a frame never switches L midway
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            l_act <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= out_en & ~sync;
            if (sync) begin
                phase <= '0;
                l_act <= l_req;
            end else if (out_en) begin
                phase <= wrap ? '0 : phase + 1'b1;
                if (wrap) l_act <= l_req;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        interp_lane #(.W(W), .GAIN_COMP(GAIN_COMP), .LW(LW)) u_lane (
            .sys_clk(sys_clk),
            .reset(reset),
            .adv(out_en),
            .sync(sync),
            .first(in_req),
            .mode(mode),
            .l_act(l_act),
            .x(x_in[k*W +: W]),
            .y(y[k*W +: W]),
            .sat_flag(sat_flag[k])
        );
    end
endmodule

// File: tb/tb_interp_zero_stuff.sv
// tb_interp_zero_stuff: directed checks of an unscaled (u0) and a gain-compensated (u1) instance
module tb_interp_zero_stuff;
    localparam int W = 18;
    logic sys_clk = 0, reset = 1, out_en = 0, sync = 0, mode = 0;
    logic [2:0] log2_l = 0;
    logic [2*W-1:0] x_in = '0, y0, y1;
    logic in_req0, in_req1, yv0, yv1;
    logic [2:0] ph0, ph1;
    logic [1:0] sat0, sat1;
    int checks = 0, errors = 0;

    always #5 sys_clk = ~sys_clk;

    interp_zero_stuff #(.NCH(2), .W(W), .MAX_LOG2L(3), .GAIN_COMP(0)) u0 (
        .sys_clk(sys_clk), .reset(reset), .out_en(out_en), .sync(sync), .mode(mode), .log2_l(log2_l),
        .x_in(x_in), .in_req(in_req0), .y(y0), .y_valid(yv0), .phase(ph0), .sat_flag(sat0));
    interp_zero_stuff #(.NCH(2), .W(W), .MAX_LOG2L(3), .GAIN_COMP(1)) u1 (
        .sys_clk(sys_clk), .reset(reset), .out_en(out_en), .sync(sync), .mode(mode), .log2_l(log2_l),
        .x_in(x_in), .in_req(in_req1), .y(y1), .y_valid(yv1), .phase(ph1), .sat_flag(sat1));

    function automatic logic signed [63:0] ln(input logic [2*W-1:0] v, input int k);
        logic signed [W-1:0] t;
        t = v[k*W +: W];
        return 64'(t);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setx(input int i, input int q);
        x_in = {W'(q), W'(i)};
    endtask

    task automatic step;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic chk_both(input string tag, input int e0i, input int e0q, input int e1i, input int e1q, input int ph);
        chk({tag, " u0.yI"}, ln(y0, 0), e0i);
        chk({tag, " u0.yQ"}, ln(y0, 1), e0q);
        chk({tag, " u1.yI"}, ln(y1, 0), e1i);
        chk({tag, " u1.yQ"}, ln(y1, 1), e1q);
        chk({tag, " phase"}, 64'(ph0), ph);
        chk({tag, " in_req"}, 64'(in_req1), (ph == 0) ? 1 : 0);
    endtask

    initial begin
        #2;
        chk_both("reset", 0, 0, 0, 0, 0);
        chk("reset y_valid", 64'(yv0), 0);
        chk("reset sat", 64'(sat1), 0);

        // zero-stuff L=4, both gain settings
        reset = 0; log2_l = 3'd2; mode = 0; out_en = 1; sync = 1; setx(1000, -1000);
        step;
        chk_both("sync", 0, 0, 0, 0, 0);
        chk("sync y_valid", 64'(yv0), 0);
        sync = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (i % 4 == 0) chk_both("zs", 1000, -1000, 4000, -4000, (i + 1) % 4);
            else chk_both("zs", 0, 0, 0, 0, (i + 1) % 4);
            chk("zs y_valid", 64'(yv1), 1);
        end
        setx(40000, -40000);
        step;
        chk_both("sat", 40000, -40000, 131071, -131072, 1);
        chk("sat u1 flag", 64'(sat1), 3);
        chk("sat u0 flag", 64'(sat0), 0);
        for (int i = 0; i < 3; i++) step;
        chk_both("sat end", 0, 0, 0, 0, 0);
        chk("sat sticky", 64'(sat1), 3);

        // sample-and-hold L=8
        mode = 1; log2_l = 3'd3; sync = 1;
        step;
        chk("sync clears sat", 64'(sat1), 0);
        sync = 0; setx(-5, 7);
        for (int i = 0; i < 8; i++) begin
            step;
            chk_both("hold", -5, 7, -5, 7, (i + 1) % 8);
            setx(99, 99);
        end

        // log2_l change mid-frame applies at the next frame
        mode = 0; log2_l = 3'd1; sync = 1; setx(1000, -1000);
        step;
        sync = 0;
        step;
        chk_both("l2 p0", 1000, -1000, 2000, -2000, 1);
        log2_l = 3'd2;
        step;
        chk_both("l2 wrap", 0, 0, 0, 0, 0);
        step;
        chk_both("l4 p0", 1000, -1000, 4000, -4000, 1);
        step; step;
        chk_both("l4 p3", 0, 0, 0, 0, 3);
        step;
        chk_both("l4 wrap", 0, 0, 0, 0, 0);

        // sparse out_en, sync mid-frame
        setx(40000, 0);
        step;
        chk_both("sp e1", 40000, 0, 131071, 0, 1);
        out_en = 0;
        step;
        chk("sp idle y_valid", 64'(yv0), 0);
        step; step;
        chk_both("sp hold y", 40000, 0, 131071, 0, 1);
        chk("sp sat", 64'(sat1), 1);
        out_en = 1;
        step;
        chk_both("sp e2", 0, 0, 0, 0, 2);
        out_en = 0; step; step; step;
        out_en = 1; sync = 1;
        step;
        chk_both("sp sync", 0, 0, 0, 0, 0);
        chk("sp sync sat", 64'(sat1), 0);
        chk("sp sync y_valid", 64'(yv1), 0);
        sync = 0; out_en = 0; setx(1000, -1000);
        step; step; step;
        out_en = 1;
        step;
        chk_both("sp consume", 1000, -1000, 4000, -4000, 1);

        // async reset mid-frame, then clamp log2_l=7 to L=8
        mode = 1; sync = 1;
        step;
        sync = 0; setx(777, 0);
        step; step; step;
        chk_both("pre rst", 777, 0, 777, 0, 3);
        out_en = 0;
        #2 reset = 1;
        #1 chk_both("async rst", 0, 0, 0, 0, 0);
        step;
        reset = 0; log2_l = 3'd7; mode = 0; out_en = 1; setx(1000, -1000);
        step;
        chk_both("rst first", 1000, -1000, 1000, -1000, 0);
        for (int i = 0; i < 8; i++) begin
            step;
            if (i == 0) chk_both("l8", 1000, -1000, 8000, -8000, 1);
            else chk_both("l8", 0, 0, 0, 0, (i + 1) % 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
